// File: rtl/sargantana_icache_ctrl.sv
// Sargantana L1 instruction cache sequencer: fetch lookup, miss refill with
// victim selection and write-back of the returned line, and set-by-set valid flush.
module sargantana_icache_ctrl #(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_N_SETS    = 64,
  parameter int ICACHE_IDX_WIDTH = $clog2(ICACHE_N_SETS),
  parameter int ICACHE_TAG_WIDTH = 20,
  parameter int WAY_WIDHT        = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0]              req_idx_i,
  input  logic                                     req_kill_i,
  input  logic                                     tag_valid_i,
  input  logic [ICACHE_TAG_WIDTH-1:0]              tag_i,
  output logic                                     array_en_o,
  output logic [ICACHE_IDX_WIDTH-1:0]              array_idx_o,
  output logic                                     cmp_enable_o,
  input  logic [ICACHE_N_WAY-1:0]                  hit_i,
  input  logic [ICACHE_N_WAY-1:0]                  valid_bits_i,
  output logic                                     resp_valid_o,
  output logic                                     ifill_req_valid_o,
  input  logic                                     ifill_req_ready_i,
  output logic [ICACHE_TAG_WIDTH+ICACHE_IDX_WIDTH-1:0] ifill_paddr_o,
  input  logic                                     ifill_resp_valid_i,
  input  logic [WAY_WIDHT-1:0]                     ifill_data_i,
  output logic [ICACHE_N_WAY-1:0]                  way_we_o,
  output logic [ICACHE_TAG_WIDTH-1:0]              wr_tag_o,
  output logic [WAY_WIDHT-1:0]                     wr_data_o,
  input  logic                                     flush_i,
  output logic                                     valid_clr_o,
  output logic                                     flush_done_o
);

  localparam int WAY_IDX_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  typedef enum logic [2:0] {
    IDLE, READ, COMPARE, MISS_REQ, MISS_WAIT, WRITE, FLUSH
  } state_t;

  state_t                        state, state_next;
  logic [ICACHE_IDX_WIDTH-1:0]   idx_q, flush_cnt;
  logic [ICACHE_TAG_WIDTH-1:0]   tag_q;
  logic [WAY_IDX_W-1:0]          victim_q, rr_ptr, free_way, victim;
  logic [WAY_WIDHT-1:0]          line_q;
  logic                          all_valid, killed, flush_pend;
  logic                          req_fire, miss_fire, last_set;

  // Lowest-index invalid way wins; round-robin only when the set is full.
  always_comb begin
    free_way  = '0;
    all_valid = &valid_bits_i;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!valid_bits_i[i]) free_way = WAY_IDX_W'(i);
    end
    victim = all_valid ? rr_ptr : free_way;
  end

  assign last_set      = (flush_cnt == ICACHE_IDX_WIDTH'(ICACHE_N_SETS - 1));
  assign req_ready_o   = (state == IDLE) && !flush_pend && !flush_i;
  assign req_fire      = req_ready_o && req_valid_i;
  assign ifill_paddr_o = {tag_q, idx_q};
  assign wr_tag_o      = tag_q;
  assign wr_data_o     = line_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next        = state;
    array_en_o        = 1'b0;
    array_idx_o       = idx_q;
    cmp_enable_o      = 1'b0;
    resp_valid_o      = 1'b0;
    ifill_req_valid_o = 1'b0;
    way_we_o          = '0;
    valid_clr_o       = 1'b0;
    flush_done_o      = 1'b0;
    miss_fire         = 1'b0;
    case (state)
      IDLE: begin
        if (flush_pend || flush_i) begin
          state_next = FLUSH;
        end else if (req_fire) begin
          array_en_o  = 1'b1;
          array_idx_o = req_idx_i;
          state_next  = READ;
        end
      end
      READ: state_next = req_kill_i ? IDLE : COMPARE;
      COMPARE: begin
        cmp_enable_o = 1'b1;
        if (req_kill_i) begin
          state_next = IDLE;
        end else if (tag_valid_i) begin
          if (|hit_i) begin
            resp_valid_o = 1'b1;
            state_next   = IDLE;
          end else begin
            miss_fire  = 1'b1;
            state_next = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (req_kill_i) begin
          state_next = IDLE;
        end else begin
          ifill_req_valid_o = 1'b1;
          if (ifill_req_ready_i) state_next = MISS_WAIT;
        end
      end
      MISS_WAIT: if (ifill_resp_valid_i) state_next = WRITE;
      // The write happens regardless of a kill; only the replay is dropped.
      WRITE: begin
        way_we_o[victim_q] = 1'b1;
        if (killed || req_kill_i) begin
          state_next = IDLE;
        end else begin
          array_en_o = 1'b1;
          state_next = READ;
        end
      end
      FLUSH: begin
        valid_clr_o = 1'b1;
        array_idx_o = flush_cnt;
        if (last_set) begin
          flush_done_o = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q      <= '0;
      tag_q      <= '0;
      victim_q   <= '0;
      rr_ptr     <= '0;
      line_q     <= '0;
      killed     <= 1'b0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (req_fire) idx_q <= req_idx_i;
      if (miss_fire) begin
        tag_q    <= tag_i;
        victim_q <= victim;
        if (all_valid) rr_ptr <= rr_ptr + WAY_IDX_W'(1);
      end
      if (state == MISS_WAIT && ifill_resp_valid_i) line_q <= ifill_data_i;
      if (state == WRITE)                          killed <= 1'b0;
      else if (state == MISS_WAIT && req_kill_i)   killed <= 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + ICACHE_IDX_WIDTH'(1);
      if (flush_done_o)   flush_pend <= 1'b0;
      else if (flush_i)   flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Directed bench for sargantana_icache_ctrl: hit, misses, round-robin, kill,
// flush during a miss and asynchronous reset mid-refill.
module tb_sargantana_icache_ctrl;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req_valid = 1'b0;
  logic [5:0]   req_idx = '0;
  logic         req_kill = 1'b0;
  logic         tag_valid = 1'b0;
  logic [19:0]  tag_in = '0;
  logic [3:0]   hit = '0;
  logic [3:0]   valid_bits = '0;
  logic         ifill_ready = 1'b0;
  logic         ifill_resp = 1'b0;
  logic [255:0] ifill_data = '0;
  logic         flush = 1'b0;

  logic         req_ready, array_en, cmp_enable, resp_valid, ifill_req_valid;
  logic         valid_clr, flush_done;
  logic [5:0]   array_idx;
  logic [25:0]  ifill_paddr;
  logic [3:0]   way_we;
  logic [19:0]  wr_tag;
  logic [255:0] wr_data;
  logic [255:0] line;

  int n_cmp = 0;
  int n_err = 0;

  sargantana_icache_ctrl dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_idx_i          (req_idx),
    .req_kill_i         (req_kill),
    .tag_valid_i        (tag_valid),
    .tag_i              (tag_in),
    .array_en_o         (array_en),
    .array_idx_o        (array_idx),
    .cmp_enable_o       (cmp_enable),
    .hit_i              (hit),
    .valid_bits_i       (valid_bits),
    .resp_valid_o       (resp_valid),
    .ifill_req_valid_o  (ifill_req_valid),
    .ifill_req_ready_i  (ifill_ready),
    .ifill_paddr_o      (ifill_paddr),
    .ifill_resp_valid_i (ifill_resp),
    .ifill_data_i       (ifill_data),
    .way_we_o           (way_we),
    .wr_tag_o           (wr_tag),
    .wr_data_o          (wr_data),
    .flush_i            (flush),
    .valid_clr_o        (valid_clr),
    .flush_done_o       (flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    @(negedge clk);
    req_valid   = 1'b0;
    req_kill    = 1'b0;
    tag_valid   = 1'b0;
    hit         = '0;
    ifill_ready = 1'b0;
    ifill_resp  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Full 0-wait miss followed by the replay hit.
  task automatic runMiss(input string name, input logic [5:0] idx, input logic [19:0] tag,
                         input logic [3:0] vbits, input logic [3:0] exp_we);
    applyStimulus(); req_valid = 1'b1; req_idx = idx; #1;
    checkOutput({name, "_hs_ready"}, req_ready, 1);
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; tag_in = tag; valid_bits = vbits; #1;
    checkOutput({name, "_cmp_resp"}, resp_valid, 0);
    applyStimulus(); ifill_ready = 1'b1; #1;
    checkOutput({name, "_paddr"}, ifill_paddr, {tag, idx});
    applyStimulus(); ifill_resp = 1'b1; ifill_data = line; #1;
    applyStimulus(); #1;
    checkOutput({name, "_we"}, way_we, exp_we);
    checkOutput({name, "_wr_tag"}, wr_tag, tag);
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; hit = exp_we; #1;
    checkOutput({name, "_replay"}, resp_valid, 1);
  endtask

  initial begin
    line = {4{64'h0123_4567_89AB_CDEF}};

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_array_en", array_en, 0);
    checkOutput("rst_ifill_req", ifill_req_valid, 0);
    checkOutput("rst_way_we", way_we, 0);
    checkOutput("rst_valid_clr", valid_clr, 0);
    checkOutput("rst_paddr", ifill_paddr, 0);
    applyStimulus(); rstn = 1'b1;

    // Hit at idx 5
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd5; #1;
    checkOutput("hit_array_en", array_en, 1);
    checkOutput("hit_array_idx", array_idx, 5);
    applyStimulus(); #1;
    checkOutput("hit_read_ready", req_ready, 0);
    checkOutput("hit_read_resp", resp_valid, 0);
    applyStimulus(); tag_valid = 1'b1; hit = 4'b0010; #1;
    checkOutput("hit_cmp_en", cmp_enable, 1);
    checkOutput("hit_resp", resp_valid, 1);
    checkOutput("hit_no_ifill", ifill_req_valid, 0);
    applyStimulus(); #1;
    checkOutput("hit_next_ready", req_ready, 1);

    // Miss with an invalid way and a slow L2 handshake
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd5; #1;
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; tag_in = 20'hABCDE; valid_bits = 4'b1011; #1;
    checkOutput("miss_cmp_resp", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(); #1;
      checkOutput("miss_hold_valid", ifill_req_valid, 1);
      checkOutput("miss_hold_paddr", ifill_paddr, {20'hABCDE, 6'd5});
    end
    applyStimulus(); ifill_ready = 1'b1; #1;
    checkOutput("miss_hs_valid", ifill_req_valid, 1);
    applyStimulus(); ifill_resp = 1'b1; ifill_data = line; #1;
    checkOutput("miss_wait_valid", ifill_req_valid, 0);
    applyStimulus(); #1;
    checkOutput("miss_we", way_we, 4'b0100);
    checkOutput("miss_wr_idx", array_idx, 5);
    checkOutput("miss_replay_en", array_en, 1);
    checkOutput("miss_wr_tag", wr_tag, 20'hABCDE);
    checkOutput("miss_wr_data_lo", wr_data[63:0], 64'h0123_4567_89AB_CDEF);
    checkOutput("miss_wr_data_hi", wr_data[255:192], 64'h0123_4567_89AB_CDEF);
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; hit = 4'b0100; #1;
    checkOutput("miss_replay_resp", resp_valid, 1);

    // Round-robin over full sets
    runMiss("rr0", 6'd1, 20'h00011, 4'b1111, 4'b0001);
    runMiss("rr1", 6'd2, 20'h00022, 4'b1111, 4'b0010);
    runMiss("rr2", 6'd3, 20'h00033, 4'b1111, 4'b0100);
    runMiss("rr3", 6'd4, 20'h00044, 4'b1111, 4'b1000);
    runMiss("rr4", 6'd6, 20'h00066, 4'b1111, 4'b0001);

    // Kill while waiting for the refill
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd9; #1;
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; tag_in = 20'h55555; valid_bits = 4'b0111; #1;
    applyStimulus(); ifill_ready = 1'b1; #1;
    checkOutput("kill_req_valid", ifill_req_valid, 1);
    applyStimulus(); req_kill = 1'b1; #1;
    applyStimulus(); ifill_resp = 1'b1; ifill_data = line; #1;
    applyStimulus(); #1;
    checkOutput("kill_we", way_we, 4'b1000);
    checkOutput("kill_no_replay", array_en, 0);
    applyStimulus(); #1;
    checkOutput("kill_ready", req_ready, 1);
    checkOutput("kill_resp", resp_valid, 0);

    // Flush raised while a miss is outstanding
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd12; #1;
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; tag_in = 20'h0F0F0; valid_bits = 4'b1111; #1;
    applyStimulus(); ifill_ready = 1'b1; #1;
    applyStimulus(); flush = 1'b1; #1;
    checkOutput("fl_wait_ready", req_ready, 0);
    applyStimulus(); ifill_resp = 1'b1; ifill_data = line; #1;
    applyStimulus(); #1;
    checkOutput("fl_we", way_we, 4'b0010);
    checkOutput("fl_replay_en", array_en, 1);
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; hit = 4'b0010; #1;
    checkOutput("fl_replay_resp", resp_valid, 1);
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd20; #1;
    checkOutput("fl_idle_ready", req_ready, 0);
    checkOutput("fl_idle_en", array_en, 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(); req_valid = 1'b1; #1;
      checkOutput("fl_clr", valid_clr, 1);
      checkOutput("fl_idx", array_idx, i);
      checkOutput("fl_done", flush_done, (i == 63) ? 1 : 0);
      checkOutput("fl_blocked", req_ready, 0);
    end
    applyStimulus(); #1;
    checkOutput("fl_after_ready", req_ready, 1);
    checkOutput("fl_after_clr", valid_clr, 0);
    checkOutput("fl_after_done", flush_done, 0);

    // Asynchronous reset in MISS_REQ
    applyStimulus(); req_valid = 1'b1; req_idx = 6'd3; #1;
    applyStimulus(); #1;
    applyStimulus(); tag_valid = 1'b1; tag_in = 20'h12345; valid_bits = 4'b1111; #1;
    applyStimulus(); #1;
    checkOutput("rst_mid_req_valid", ifill_req_valid, 1);
    rstn = 1'b0; #1;
    checkOutput("rst_mid_ifill", ifill_req_valid, 0);
    checkOutput("rst_mid_paddr", ifill_paddr, 0);
    checkOutput("rst_mid_cmp", cmp_enable, 0);
    checkOutput("rst_mid_wr_tag", wr_tag, 0);
    checkOutput("rst_mid_idx", array_idx, 0);
    applyStimulus(); rstn = 1'b1; #1;
    checkOutput("rst_rel_ready", req_ready, 1);
    runMiss("post_rst", 6'd7, 20'h00777, 4'b1111, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
